s444_state_bank: RTL and testbench

// - 21-bit state register bank closing the loop around the combinational s444 next-state core.
// - Drives present state into core inputs G11..G31; captures core next-state outputs n19..n119.
// - Adds a serial scan path (load/unload of full state) under a small shift FSM for test access.

---
 rtl/s444_state_bank.sv | 106 ++++++++++
 tb/tb_s444_state_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/s444_state_bank.sv
// State register bank around the s444 next-state core, with a serial scan load/unload path.
// Optional sticky capture-parity checking is enabled by defining S444_STATE_PARITY_EN.
module s444_state_bank #(
    parameter int                   STATE_W   = 21,
    parameter logic [STATE_W-1:0]   RESET_VAL = '0,
    parameter int                   CNT_W     = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [STATE_W-1:0]  i_ns_in,
    output logic [STATE_W-1:0]  o_ps_out,
    input  logic                i_func_en,
    input  logic                i_scan_start,
    input  logic                i_scan_si,
    output logic                o_scan_so,
    output logic                o_scan_busy,
    output logic                o_scan_done
`ifdef S444_STATE_PARITY_EN
    ,
    input  logic                i_ns_par_in,
    output logic                o_par_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [STATE_W-1:0] r_ps;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    logic w_idle;
    logic w_capture;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_capture = w_idle && !i_scan_start && i_func_en;

`ifdef S444_STATE_PARITY_EN
    logic r_par_err;
    logic w_par_bad;
    assign w_par_bad = (^i_ns_in) ^ i_ns_par_in;
    assign o_par_err = r_par_err;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ps    <= RESET_VAL;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef S444_STATE_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_scan_start) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef S444_STATE_PARITY_EN
                        r_par_err <= 1'b0;
`endif
                    end else if (i_func_en) begin
                        r_ps <= i_ns_in;
`ifdef S444_STATE_PARITY_EN
                        if (w_capture && w_par_bad) begin
                            r_par_err <= 1'b1;
                        end
`endif
                    end
                end
                ST_SHIFT: begin
                    // Shift toward bit 0 so the oldest bit leaves on scan_so first.
                    r_ps  <= {i_scan_si, r_ps[STATE_W-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(STATE_W - 1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ps_out    = r_ps;
    assign o_scan_so   = r_ps[0];
    assign o_scan_busy = r_busy;
    assign o_scan_done = r_done;

endmodule

// File: tb/tb_s444_state_bank.sv
// Randomized and directed bench for s444_state_bank against a cycle-count based reference model.
module tb_s444_state_bank;
    localparam int W = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst   = 1'b1;
    logic         fen   = 1'b0;
    logic         start = 1'b0;
    logic         si    = 1'b0;
    logic [W-1:0] ns    = '0;
    logic [W-1:0] ps;
    logic         so, busy, done;
`ifdef S444_STATE_PARITY_EN
    logic         par = 1'b0;
    logic         perr;
`endif

    s444_state_bank dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_ns_in      (ns),
        .o_ps_out     (ps),
        .i_func_en    (fen),
        .i_scan_start (start),
        .i_scan_si    (si),
        .o_scan_so    (so),
        .o_scan_busy  (busy),
        .o_scan_done  (done)
`ifdef S444_STATE_PARITY_EN
        ,
        .i_ns_par_in  (par),
        .o_par_err    (perr)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference model: m_scan counts cycles since an accepted scan_start (0 = idle),
    // cycles 1..W shift, cycle W+1 is the done cycle.
    logic [W-1:0] m_ps   = '0;
    int           m_scan = 0;
    logic         m_perr = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ps = '0; m_scan = 0; m_perr = 1'b0;
        end else if (m_scan == 0) begin
            if (start) begin
                m_scan = 1; m_perr = 1'b0;
            end else if (fen) begin
                m_ps = ns;
`ifdef S444_STATE_PARITY_EN
                if ((^ns) != par) m_perr = 1'b1;
`endif
            end
        end else if (m_scan <= W) begin
            m_ps = {si, m_ps[W-1:1]};
            m_scan++;
        end else begin
            m_scan = 0;
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ps_out",    32'(ps),   32'(m_ps));
            chk("scan_so",   32'(so),   32'(m_ps[0]));
            chk("scan_busy", 32'(busy), 32'(m_scan != 0));
            chk("scan_done", 32'(done), 32'(m_scan == W + 1));
`ifdef S444_STATE_PARITY_EN
            chk("par_err",   32'(perr), 32'(m_perr));
`endif
        end
    end

    task automatic wait_done(input string name);
        int cycles = 1;
        while (!done && cycles < 40) begin
            si = 1'($urandom);
            @(negedge clk);
            cycles++;
        end
        chk(name, 32'(cycles), 32'd22);
    endtask

    initial begin
        logic [W-1:0] sob;
        sob = '0;

        // reset
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_ps", 32'(ps), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // capture and hold
        fen = 1'b1; ns = 21'h15A5A5;
`ifdef S444_STATE_PARITY_EN
        par = ^ns;
`endif
        @(negedge clk);
        chk("cap", 32'(ps), 32'h15A5A5);
        fen = 1'b0; ns = 21'h0ABCDE;
        @(negedge clk);
        chk("hold", 32'(ps), 32'h15A5A5);

        // scan unload of all ones while loading zeros
        fen = 1'b1; ns = 21'h1FFFFF;
`ifdef S444_STATE_PARITY_EN
        par = ^ns;
`endif
        @(negedge clk);
        fen = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; si = 1'b0;
        for (int i = 0; i < W; i++) begin
            sob[i] = so;
            @(negedge clk);
        end
        chk("scan_so_bits", 32'(sob), 32'h1FFFFF);
        chk("scan_ps_zero", 32'(ps), 32'd0);
        chk("scan_done22", 32'(done), 32'd1);
        @(negedge clk);
        chk("scan_idle_busy", 32'(busy), 32'd0);

        // priority: scan_start beats func_en, then both ignored while busy
        fen = 1'b1; ns = 21'h123456;
`ifdef S444_STATE_PARITY_EN
        par = ^ns;
`endif
        @(negedge clk);
        start = 1'b1; ns = 21'h0000FF;
        @(negedge clk);
        chk("prio_busy", 32'(busy), 32'd1);
        chk("prio_ps", 32'(ps), 32'h123456);
        wait_done("busy_ignore_len");
        start = 1'b0; fen = 1'b0;
        @(negedge clk);
        chk("busy_ignore_idle", 32'(busy), 32'd0);

        // reset mid-shift at cnt=7
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_ps", 32'(ps), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midrst_restart_len");
        @(negedge clk);

`ifdef S444_STATE_PARITY_EN
        fen = 1'b1; ns = 21'h000001; par = 1'b0;
        @(negedge clk);
        chk("par_set", 32'(perr), 32'd1);
        repeat (3) begin
            ns = W'($urandom); par = ^ns;
            @(negedge clk);
        end
        chk("par_sticky", 32'(perr), 32'd1);
        fen = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("par_clear", 32'(perr), 32'd0);
        wait_done("par_scan_len");
        @(negedge clk);
`endif

        // randomized traffic
        repeat (2000) begin
            rst   = ($urandom % 150) == 0;
            start = ($urandom % 16) == 0;
            fen   = 1'($urandom);
            si    = 1'($urandom);
            ns    = W'($urandom);
`ifdef S444_STATE_PARITY_EN
            par   = (^ns) ^ (($urandom % 6) == 0);
`endif
            @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
